// File: rtl/gpio_out_if.sv
// gpio_out_if: registered GPIO pad driver with aux output mux and dead time on newly enabled pads.
module gpio_out_if #(
  parameter int GW       = 32,
  parameter int DEAD_CYC = 4,
  parameter int CW       = 8
) (
  input  logic          sys_clk,
  input  logic          sys_rst,
  input  logic          out_load,
  input  logic [GW-1:0] out_data,
  input  logic [GW-1:0] oe_data,
  input  logic [GW-1:0] aux_sel,
  input  logic [GW-1:0] aux_o,
  output logic [GW-1:0] gpio_o,
  output logic [GW-1:0] gpio_oen,
  output logic          busy
);
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] DEAD = 1'b1;
  localparam logic [CW-1:0] DEAD_LD = CW'(DEAD_CYC);
  logic [0:0] state_q, state_d;
  logic [GW-1:0] out_q, out_d, oe_q, oe_d, pend_q, pend_d, newen;
  logic [CW-1:0] cnt_q, cnt_d;
  logic acc, start, done;
  // Loads are only accepted outside a dead window; newly enabled bits stay tristated until it ends.
  always_comb begin
    acc     = out_load & (state_q == IDLE);
    newen   = oe_data & ~oe_q;
    start   = acc & (|newen) & (DEAD_CYC != 0);
    done    = (state_q == DEAD) & (cnt_q == CW'(1));
    out_d   = acc ? out_data : out_q;
    oe_d    = acc ? oe_data : oe_q;
    pend_d  = start ? newen : done ? '0 : pend_q;
    cnt_d   = start ? DEAD_LD : (state_q == DEAD) ? cnt_q - CW'(1) : cnt_q;
    state_d = start ? DEAD : done ? IDLE : state_q;
  end
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q  <= IDLE;
      out_q    <= '0;
      oe_q     <= '0;
      pend_q   <= '0;
      cnt_q    <= '0;
      gpio_o   <= '0;
      gpio_oen <= '1;
    end else begin
      state_q  <= state_d;
      out_q    <= out_d;
      oe_q     <= oe_d;
      pend_q   <= pend_d;
      cnt_q    <= cnt_d;
      gpio_o   <= (aux_sel & aux_o) | (~aux_sel & out_d);
      gpio_oen <= ~(oe_d & ~pend_d);
    end
  end
  assign busy = (state_q == DEAD);
endmodule

// File: tb/tb_gpio_out_if.sv
// tb_gpio_out_if: vector table, directed corner sequences and randomized model check of gpio_out_if.
module tb_gpio_out_if;
  localparam int D = 4;
  logic sys_clk = 1'b0, sys_rst = 1'b0, ld = 1'b0;
  logic [31:0] od = '0, oe = '0, as = '0, ax = '0;
  logic [31:0] go, goen, go0, goen0;
  logic bsy, bsy0;
  int errors = 0, checks = 0;
  always #5 sys_clk = ~sys_clk;

  gpio_out_if #(.GW(32), .DEAD_CYC(D), .CW(8)) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .out_load(ld), .out_data(od), .oe_data(oe),
    .aux_sel(as), .aux_o(ax), .gpio_o(go), .gpio_oen(goen), .busy(bsy));
  gpio_out_if #(.GW(32), .DEAD_CYC(0), .CW(8)) dut0 (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .out_load(ld), .out_data(od), .oe_data(oe),
    .aux_sel(as), .aux_o(ax), .gpio_o(go0), .gpio_oen(goen0), .busy(bsy0));

  typedef struct {
    logic ld;
    logic [31:0] od, oe, as, ax, eo, eoen;
    logic eb;
  } vec_t;
  vec_t tbl[16];

  // Time-based reference: the window is an absolute edge deadline rather than a countdown.
  int k, win_end;
  logic [31:0] out_m, oe_m, pend_m, out0, oe0;
  logic busy_m;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic model_reset();
    k = 0; win_end = 0; out_m = '0; oe_m = '0; pend_m = '0; busy_m = 1'b0; out0 = '0; oe0 = '0;
  endtask

  task automatic model_edge();
    logic [31:0] newen;
    k++;
    if (ld && !busy_m) begin
      newen = oe & ~oe_m;
      oe_m = oe;
      out_m = od;
      if (newen != 0) begin
        pend_m = newen;
        win_end = k + D;
      end
    end
    if (k >= win_end) pend_m = '0;
    busy_m = k < win_end;
    if (ld) begin
      out0 = od;
      oe0 = oe;
    end
  endtask

  initial begin
    tbl[0]  = '{1'b1, 32'h0000_0055, 32'h0000_00FF, 32'h0, 32'h0, 32'h0000_0055, 32'hFFFF_FFFF, 1'b1};
    tbl[1]  = '{1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0000_0055, 32'hFFFF_FFFF, 1'b1};
    tbl[2]  = '{1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0000_0055, 32'hFFFF_FFFF, 1'b1};
    tbl[3]  = '{1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0000_0055, 32'hFFFF_FFFF, 1'b1};
    tbl[4]  = '{1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0000_0055, 32'hFFFF_FF00, 1'b0};
    tbl[5]  = '{1'b1, 32'h0, 32'h0000_FF00, 32'h0, 32'h0, 32'h0, 32'hFFFF_FFFF, 1'b1};
    tbl[6]  = '{1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'hFFFF_FFFF, 1'b1};
    tbl[7]  = '{1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'hFFFF_FFFF, 1'b1};
    tbl[8]  = '{1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'hFFFF_FFFF, 1'b1};
    tbl[9]  = '{1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'hFFFF_00FF, 1'b0};
    tbl[10] = '{1'b1, 32'h0, 32'hFFFF_FFFF, 32'h0, 32'h0, 32'h0, 32'hFFFF_00FF, 1'b1};
    tbl[11] = '{1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'hFFFF_00FF, 1'b1};
    tbl[12] = '{1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'hFFFF_00FF, 1'b1};
    tbl[13] = '{1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'hFFFF_00FF, 1'b1};
    tbl[14] = '{1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0000_0000, 1'b0};
    tbl[15] = '{1'b1, 32'hA5A5_A5A5, 32'hFFFF_FFFF, 32'h0, 32'h0, 32'hA5A5_A5A5, 32'h0000_0000, 1'b0};

    #3 sys_rst = 1'b1;
    #1;
    chk("rst_o", go, 32'h0);
    chk("rst_oen", goen, 32'hFFFF_FFFF);
    chk("rst_busy", {31'b0, bsy}, 32'h0);
    @(posedge sys_clk);
    #3 sys_rst = 1'b0;

    for (int i = 0; i < 16; i++) begin
      ld = tbl[i].ld; od = tbl[i].od; oe = tbl[i].oe; as = tbl[i].as; ax = tbl[i].ax;
      step();
      chk($sformatf("vec%0d_o", i), go, tbl[i].eo);
      chk($sformatf("vec%0d_oen", i), goen, tbl[i].eoen);
      chk($sformatf("vec%0d_busy", i), {31'b0, bsy}, {31'b0, tbl[i].eb});
    end

    ld = 1'b1; od = 32'h0000_ABCD; oe = 32'h0; as = 32'h0; ax = 32'h0;
    step();
    chk("dis_oen", goen, 32'hFFFF_FFFF);
    chk("dis_busy", {31'b0, bsy}, 32'h0);
    oe = 32'h0000_00FF; as = 32'hFFFF_0000; ax = 32'h1234_5678;
    step();
    chk("aux_o", go, 32'h1234_ABCD);
    chk("aux_busy", {31'b0, bsy}, 32'h1);
    ld = 1'b0; ax = 32'h0;
    step();
    chk("aux_tog", go, 32'h0000_ABCD);
    ld = 1'b1; od = 32'hFFFF_FFFF; oe = 32'hFFFF_FFFF;
    step();
    chk("lock_o", go, 32'h0000_ABCD);
    ld = 1'b0;
    step();
    chk("lock_busy3", {31'b0, bsy}, 32'h1);
    step();
    chk("lock_busy4", {31'b0, bsy}, 32'h0);
    chk("lock_oen", goen, 32'hFFFF_FF00);
    chk("lock_o2", go, 32'h0000_ABCD);

    ld = 1'b1; od = 32'h0; oe = 32'h0000_FF00; as = 32'h0;
    step();
    ld = 1'b0;
    step();
    chk("mid_busy", {31'b0, bsy}, 32'h1);
    #3 sys_rst = 1'b1;
    #1;
    chk("mid_rst_o", go, 32'h0);
    chk("mid_rst_oen", goen, 32'hFFFF_FFFF);
    chk("mid_rst_busy", {31'b0, bsy}, 32'h0);
    chk("mid_rst_oen0", goen0, 32'hFFFF_FFFF);
    @(posedge sys_clk);
    #3 sys_rst = 1'b0;
    step();
    chk("post_busy", {31'b0, bsy}, 32'h0);
    chk("post_oen", goen, 32'hFFFF_FFFF);
    ld = 1'b1; od = 32'h5; oe = 32'h0000_000F;
    step();
    chk("d0_oen", goen0, 32'hFFFF_FFF0);
    chk("d0_o", go0, 32'h5);
    chk("d0_busy", {31'b0, bsy0}, 32'h0);
    chk("d4_busy", {31'b0, bsy}, 32'h1);
    chk("d4_oen", goen, 32'hFFFF_FFFF);
    ld = 1'b0;

    #3 sys_rst = 1'b1;
    @(posedge sys_clk);
    #3 sys_rst = 1'b0;
    model_reset();
    for (int i = 0; i < 400; i++) begin
      ld = ($urandom_range(0, 2) == 0);
      od = $urandom;
      oe = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
      as = ($urandom_range(0, 1) == 0) ? 32'h0 : $urandom;
      ax = $urandom;
      step();
      model_edge();
      chk("rnd_o", go, (as & ax) | (~as & out_m));
      chk("rnd_oen", goen, ~(oe_m & ~pend_m));
      chk("rnd_busy", {31'b0, bsy}, {31'b0, busy_m});
      chk("rnd0_o", go0, (as & ax) | (~as & out0));
      chk("rnd0_oen", goen0, ~oe0);
      chk("rnd0_busy", {31'b0, bsy0}, 32'h0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
